// File: rtl/mac_feeder.sv
// Sequences signed operand pairs into a downstream mac_pe, one pair per cycle,
// and returns each vector's dot product together with its pair count.
module mac_feeder #(
  parameter int unsigned MAX_LEN = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [7:0]  in_a,
  input  logic signed [7:0]  in_b,
  input  logic               in_last,
  output logic               mac_rst,
  output logic signed [7:0]  mac_a,
  output logic signed [7:0]  mac_b,
  input  logic signed [15:0] mac_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_result,
  output logic [7:0]         out_count,
  output logic               out_err
);

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            err;
  logic            drain_cnt;

  logic            hs;
  logic            at_limit;
  logic            capture;
  logic            in_ready_nxt;
  logic            out_valid_nxt;
  logic [DW-1:0]   mac_a_nxt;
  logic [DW-1:0]   mac_b_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DRAIN spans two cycles so mac_pe absorbs the final pair
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = CLEAR;
      CLEAR:   state_nxt = FEED;
      FEED:    if (hs && (in_last || at_limit)) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = HOLD;
      HOLD:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; mac_rst follows rst combinationally so mac_pe clears in the same cycle
  always_comb begin
    hs            = in_valid & in_ready;
    at_limit      = (cnt == LAST_IDX);
    capture       = (state == DRAIN) && drain_cnt;
    mac_rst       = rst | (state == CLEAR);
    in_ready_nxt  = (state_nxt == FEED);
    out_valid_nxt = (state_nxt == HOLD);
    mac_a_nxt     = '0;
    mac_b_nxt     = '0;
    if (hs) begin
      mac_a_nxt = in_a;
      mac_b_nxt = in_b;
    end
  end

  // Registered handshakes and operands; a missing beat feeds a zero product
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
    end else begin
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      mac_a     <= mac_a_nxt;
      mac_b     <= mac_b_nxt;
    end
  end

  // Beat counter, truncation flag and drain timer
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      err       <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        cnt <= '0;
        err <= 1'b0;
      end else if (hs) begin
        cnt <= cnt + CW'(1);
        if (at_limit && !in_last) err <= 1'b1;
      end
      drain_cnt <= (state == DRAIN) && !drain_cnt;
    end
  end

  // Result capture on the edge that leaves DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_result <= '0;
      out_count  <= '0;
      out_err    <= 1'b0;
    end else if (capture) begin
      out_result <= AW'(mac_result);
      out_count  <= cnt;
      out_err    <= err;
    end
  end

endmodule
